// File: rtl/demux_scan_ctrl.sv
// Scan sequencer for a 1-to-4 demux: walks the enabled channels in ascending
// order, holding each for a latched dwell count, with one-shot/continuous
// sweeps, abort, and a completed-sweep counter.
module demux_scan_ctrl #(
   parameter int unsigned DWELL_W = 8,
   parameter int unsigned CNT_W   = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [3:0]         ch_mask,
   input  logic [DWELL_W-1:0] dwell,
   input  logic               continuous,
   input  logic               abort,
   input  logic               d_in,
   output logic [1:0]         s,
   output logic               d,
   output logic               busy,
   output logic               done,
   output logic [CNT_W-1:0]   sweep_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [3:0]         mask_q, mask_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic [DWELL_W-1:0] dcnt_q, dcnt_d;
   logic [1:0]         s_d;
   logic               busy_d;
   logic               done_d;
   logic [CNT_W-1:0]   cnt_d;
   logic [2:0]         nxt;

   // Index of the lowest set bit (0 when the mask is empty).
   function automatic logic [1:0] lowest_ch(input logic [3:0] m);
      logic [1:0] r;
      r = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (m[i]) r = 2'(i);
      end
      return r;
   endfunction

   // {valid, index} of the lowest enabled channel strictly above cur.
   function automatic logic [2:0] next_ch(input logic [3:0] m, input logic [1:0] cur);
      logic [2:0] r;
      r = 3'd0;
      for (int i = 3; i >= 0; i--) begin
         if (m[i] && (i > int'(cur))) r = {1'b1, 2'(i)};
      end
      return r;
   endfunction

   // Demux data follows d_in only while a channel is being driven.
   assign d = busy & d_in;

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         mask_q    <= 4'd0;
         dwell_q   <= DWELL_W'(1);
         dcnt_q    <= '0;
         s         <= 2'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
         sweep_cnt <= '0;
      end else begin
         state_q   <= state_d;
         mask_q    <= mask_d;
         dwell_q   <= dwell_d;
         dcnt_q    <= dcnt_d;
         s         <= s_d;
         busy      <= busy_d;
         done      <= done_d;
         sweep_cnt <= cnt_d;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      dwell_d = dwell_q;
      dcnt_d  = dcnt_q;
      s_d     = s;
      busy_d  = busy;
      done_d  = 1'b0;
      cnt_d   = sweep_cnt;
      nxt     = next_ch(mask_q, s);

      case (state_q)
         IDLE: begin
            if (start) begin
               mask_d  = ch_mask;
               dwell_d = (dwell == '0) ? DWELL_W'(1) : dwell;
               dcnt_d  = '0;
               if (ch_mask != 4'd0) begin
                  state_d = SCAN;
                  busy_d  = 1'b1;
                  s_d     = lowest_ch(ch_mask);
               end else begin
                  state_d = FIN;
                  done_d  = 1'b1;
               end
            end
         end
         SCAN: begin
            if (abort) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               s_d     = 2'd0;
            end else if (dcnt_q == dwell_q - DWELL_W'(1)) begin
               dcnt_d = '0;
               if (nxt[2]) begin
                  s_d = nxt[1:0];
               end else begin
                  cnt_d = sweep_cnt + CNT_W'(1);
                  if (continuous) begin
                     s_d = lowest_ch(mask_q);
                  end else begin
                     state_d = FIN;
                     busy_d  = 1'b0;
                     s_d     = 2'd0;
                     done_d  = 1'b1;
                  end
               end
            end else begin
               dcnt_d = dcnt_q + DWELL_W'(1);
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            s_d     = 2'd0;
         end
      endcase
   end

endmodule
